// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-wide RAM/IO arbiter: dcache bytes with priority over 16-byte icache line bursts.
// Optional MEM_CTRL_PERF_EN adds issue/stall performance counters.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_get_en,
    input  logic        d_write_mode,
    input  logic [17:0] d_addr,
    input  logic [7:0]  d_data,
    output logic        d_out_en,
    input  logic        i_req,
    input  logic [17:0] i_addr,
    output logic        i_out_en,
    output logic [3:0]  i_offset,
    output logic        i_done,
    output logic [7:0]  out_data,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [17:0] mem_a,
    output logic        mem_wr
`ifdef MEM_CTRL_PERF_EN
    ,
    output logic [31:0] perf_d_bytes,
    output logic [31:0] perf_i_bytes,
    output logic [31:0] perf_io_stall
`endif
);

    typedef enum logic {
        IDLE    = 1'b0,
        I_BURST = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [13:0] line, line_next;
    logic [3:0]  issue_cnt;
    logic [13:0] issue_line;
    logic        io_block;
    logic        d_grant;
    logic        i_issue;
    logic [3:0]  unused_i_addr_lo;

    assign unused_i_addr_lo = i_addr[3:0];

    // A UART write with the buffer full is held off entirely; the slot is free for the icache.
    assign io_block = d_get_en & d_write_mode & (d_addr[17:16] == 2'b11) & io_buffer_full;
    assign d_grant  = d_get_en & ~io_block;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            line  <= 14'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            line  <= line_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        line_next  = line;
        issue_cnt  = cnt;
        issue_line = line;
        i_issue    = 1'b0;
        case (state)
            IDLE: begin
                // i_done high means i_req is still the finished line's request.
                if (i_req && !i_done) begin
                    line_next  = i_addr[17:4];
                    issue_line = i_addr[17:4];
                    issue_cnt  = 4'd0;
                    cnt_next   = 4'd0;
                    state_next = I_BURST;
                    if (!d_grant) begin
                        i_issue  = 1'b1;
                        cnt_next = 4'd1;
                    end
                end
            end
            I_BURST: begin
                if (!d_grant) begin
                    i_issue  = 1'b1;
                    cnt_next = cnt + 4'd1;
                    if (cnt == 4'hF) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        mem_a    = 18'd0;
        mem_dout = 8'd0;
        mem_wr   = 1'b0;
        if (d_grant) begin
            mem_a    = d_addr;
            mem_dout = d_data;
            mem_wr   = d_write_mode;
        end else if (i_issue) begin
            mem_a = {issue_line, issue_cnt};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out_en <= 1'b0;
            i_out_en <= 1'b0;
            i_offset <= 4'd0;
            i_done   <= 1'b0;
        end else begin
            d_out_en <= d_grant;
            i_out_en <= i_issue;
            i_done   <= i_issue && (issue_cnt == 4'hF);
            if (i_issue) begin
                i_offset <= issue_cnt;
            end
        end
    end

    assign out_data = mem_din;

`ifdef MEM_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_d_bytes  <= 32'd0;
            perf_i_bytes  <= 32'd0;
            perf_io_stall <= 32'd0;
        end else begin
            if (d_grant) perf_d_bytes <= perf_d_bytes + 32'd1;
            if (i_issue) perf_i_bytes <= perf_i_bytes + 32'd1;
            if (io_block) perf_io_stall <= perf_io_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard bench for mem_ctrl (dcache/icache arbitration, IO gating, reset).
`timescale 1ns/1ps
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        d_get_en = 1'b0;
    logic        d_write_mode = 1'b0;
    logic [17:0] d_addr = '0;
    logic [7:0]  d_data = '0;
    logic        d_out_en;
    logic        i_req = 1'b0;
    logic [17:0] i_addr = '0;
    logic        i_out_en;
    logic [3:0]  i_offset;
    logic        i_done;
    logic [7:0]  out_data;
    logic        io_buffer_full = 1'b0;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [17:0] mem_a;
    logic        mem_wr;
`ifdef MEM_CTRL_PERF_EN
    logic [31:0] perf_d_bytes, perf_i_bytes, perf_io_stall;
    logic [31:0] pd0, pi0, ps0;
`endif

    mem_ctrl dut (
        .clk(clk), .rst(rst),
        .d_get_en(d_get_en), .d_write_mode(d_write_mode), .d_addr(d_addr), .d_data(d_data),
        .d_out_en(d_out_en),
        .i_req(i_req), .i_addr(i_addr), .i_out_en(i_out_en), .i_offset(i_offset), .i_done(i_done),
        .out_data(out_data),
        .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr)
`ifdef MEM_CTRL_PERF_EN
        ,
        .perf_d_bytes(perf_d_bytes), .perf_i_bytes(perf_i_bytes), .perf_io_stall(perf_io_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_i;
        bit [3:0]   off;
        bit         done;
        bit [7:0]   data;
        bit         chk_data;
        int         cyc;
    } resp_t;

    resp_t q[$];
    int    cycle = 0;
    int    n_total = 0;
    int    n_bad = 0;

    function automatic logic [7:0] mem_f(input logic [17:0] a);
        if (a == 18'h00104) return 8'h5A;
        return a[7:0] ^ a[15:8] ^ 8'hA5 ^ {6'd0, a[17:16]};
    endfunction

    always @(posedge clk) begin
        cycle   <= cycle + 1;
        mem_din <= mem_f(mem_a);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // Response monitor: each expected entry must appear in exactly its cycle.
    always @(negedge clk) begin
        if (!rst) begin
            resp_t e;
            if (d_out_en && i_out_en) check("both_out_en", 1, 0);
            while (q.size() > 0 && q[0].cyc < cycle) begin
                void'(q.pop_front());
                check("missing_resp", 0, 1);
            end
            if (q.size() > 0 && q[0].cyc == cycle) begin
                e = q.pop_front();
                if (e.is_i) begin
                    check("i_out_en", i_out_en, 1);
                    check("i_offset", i_offset, e.off);
                    check("i_done", i_done, e.done);
                    check("d_out_en_in_i", d_out_en, 0);
                end else begin
                    check("d_out_en", d_out_en, 1);
                    check("i_out_en_in_d", i_out_en, 0);
                    check("i_done_in_d", i_done, 0);
                end
                if (e.chk_data) check("out_data", out_data, e.data);
            end else if (d_out_en || i_out_en || i_done) begin
                check("spurious_out", {d_out_en, i_out_en, i_done}, 0);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic en, input logic wr, input logic [17:0] a, input logic [7:0] d);
        d_get_en     = en;
        d_write_mode = wr;
        d_addr       = a;
        d_data       = d;
    endtask

    // kind: 0 no access, 1 dcache, 2 icache, 3 icache whose response is killed by reset
    task automatic expect_bus(input int kind, input logic [17:0] ea, input logic ewr,
                              input logic [7:0] edout, input logic [3:0] eoff);
        resp_t e;
        @(negedge clk);
        if (kind == 0) begin
            check("idle_a", mem_a, 0);
            check("idle_wr", mem_wr, 0);
            check("idle_dout", mem_dout, 0);
        end else begin
            check(kind == 1 ? "d_mem_a" : "i_mem_a", mem_a, ea);
            check(kind == 1 ? "d_mem_wr" : "i_mem_wr", mem_wr, ewr);
            if (ewr) check("d_mem_dout", mem_dout, edout);
            if (kind != 3) begin
                e.is_i     = (kind == 2);
                e.off      = eoff;
                e.done     = (kind == 2) && (eoff == 4'hF);
                e.data     = mem_f(ea);
                e.chk_data = !ewr;
                e.cyc      = cycle + 1;
                q.push_back(e);
            end
        end
    endtask

    task automatic run_burst(input logic [17:0] base, input int pre_after);
        for (int k = 0; k < 16; k++) begin
            if (k == pre_after + 1) begin
                for (int j = 0; j < 3; j++) begin
                    next_cycle();
                    set_d(1, 0, 18'h02000 + 18'(j), 0);
                    expect_bus(1, 18'h02000 + 18'(j), 0, 0, 0);
                end
            end
            next_cycle();
            set_d(0, 0, 0, 0);
            i_req  = 1'b1;
            i_addr = base | 18'h5;
            expect_bus(2, base + 18'(k), 0, 0, 4'(k));
        end
        next_cycle();
        expect_bus(0, 0, 0, 0, 0);
        next_cycle();
        i_req = 1'b0;
        expect_bus(0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_d_out_en", d_out_en, 0);
        check("rst_i_out_en", i_out_en, 0);
        check("rst_i_offset", i_offset, 0);
        check("rst_i_done", i_done, 0);
        check("rst_mem_a", mem_a, 0);
        next_cycle();
        rst = 1'b0;
        expect_bus(0, 0, 0, 0, 0);

        // single read, write, back-to-back reads, IO read with buffer full
        next_cycle(); set_d(1, 0, 18'h00104, 8'h00); expect_bus(1, 18'h00104, 0, 0, 0);
        next_cycle(); set_d(0, 0, 0, 0);             expect_bus(0, 0, 0, 0, 0);
        next_cycle(); set_d(1, 1, 18'h00200, 8'h77); expect_bus(1, 18'h00200, 1, 8'h77, 0);
        for (int j = 0; j < 3; j++) begin
            next_cycle(); set_d(1, 0, 18'h00300 + 18'(j), 0); expect_bus(1, 18'h00300 + 18'(j), 0, 0, 0);
        end
        next_cycle(); io_buffer_full = 1'b1; set_d(1, 0, 18'h30005, 0); expect_bus(1, 18'h30005, 0, 0, 0);
        next_cycle(); io_buffer_full = 1'b0; set_d(0, 0, 0, 0);         expect_bus(0, 0, 0, 0, 0);

        run_burst(18'h01000, -1);

`ifdef MEM_CTRL_PERF_EN
        pd0 = perf_d_bytes; pi0 = perf_i_bytes; ps0 = perf_io_stall;
`endif
        run_burst(18'h04000, 5);
`ifdef MEM_CTRL_PERF_EN
        check("perf_d_bytes", perf_d_bytes - pd0, 3);
        check("perf_i_bytes", perf_i_bytes - pi0, 16);
        check("perf_io_stall", perf_io_stall - ps0, 0);
        ps0 = perf_io_stall;
`endif

        // IO write blocked while UART buffer full
        for (int j = 0; j < 4; j++) begin
            next_cycle(); io_buffer_full = 1'b1; set_d(1, 1, 18'h30000, 8'h41); expect_bus(0, 0, 0, 0, 0);
        end
        next_cycle(); io_buffer_full = 1'b0; expect_bus(1, 18'h30000, 1, 8'h41, 0);
        next_cycle(); set_d(0, 0, 0, 0);     expect_bus(0, 0, 0, 0, 0);
`ifdef MEM_CTRL_PERF_EN
        check("perf_io_stall_4", perf_io_stall - ps0, 4);
`endif

        // reset mid-burst after offset 9
        for (int k = 0; k < 10; k++) begin
            next_cycle(); i_req = 1'b1; i_addr = 18'h05000;
            expect_bus(k == 9 ? 3 : 2, 18'h05000 + 18'(k), 0, 0, 4'(k));
        end
        next_cycle(); rst = 1'b1; i_req = 1'b0;
        @(negedge clk);
        check("mid_rst_i_out_en", i_out_en, 0);
        check("mid_rst_i_done", i_done, 0);
        check("mid_rst_i_offset", i_offset, 0);
        check("mid_rst_d_out_en", d_out_en, 0);
        next_cycle(); rst = 1'b0; expect_bus(0, 0, 0, 0, 0);
        run_burst(18'h06000, -1);

        repeat (3) next_cycle();
        check("sb_drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
